// File: rtl/coef_requant_pkg.sv
// Shared constants, reader state type and the per-coefficient requantizer
// (round, arithmetic shift, saturate to QW bits).
package coef_requant_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned SHIFT = 20;
    localparam int unsigned QW    = 12;
    localparam int unsigned N     = 64;
    localparam int unsigned PW    = $clog2(N);

    typedef enum logic {
        StIdle,
        StEmit
    } rd_state_e;

    localparam logic [DW:0] RndHalf = {{(DW - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    function automatic logic [QW-1:0] requant(input logic [DW-1:0] din, input logic rnd_en);
        logic signed [DW:0] t;
        logic signed [DW:0] q;
        t = $signed({din[DW-1], din}) + $signed(rnd_en ? RndHalf : '0);
        q = t >>> SHIFT;
        // In range only when every bit above the kept sign bit matches it.
        if (&q[DW:QW-1] || ~|q[DW:QW-1]) begin
            return q[QW-1:0];
        end
        return q[DW] ? {1'b1, {(QW - 1){1'b0}}} : {1'b0, {(QW - 1){1'b1}}};
    endfunction

endpackage

// File: rtl/coef_bank.sv
// N x QW coefficient register file: one synchronous write port and one
// combinational read port. Contents are not reset.
module coef_bank
    import coef_requant_pkg::*;
(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [QW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [QW-1:0] rdata_o
);

    logic [QW-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/coef_requant.sv
// Coefficient requantizer with ping-pong block buffer: writer fills one bank
// while the reader FSM replays the other, sign-extended, under out_ready_i.
module coef_requant
    import coef_requant_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic [DW-1:0] din_i,
    input  logic          rnd_en_i,
    input  logic          out_ready_i,
    output logic          start_out_o,
    output logic [DW-1:0] dout_o,
    output logic [15:0]   blk_cnt_o,
    output logic          ovf_o
);

    localparam logic [PW-1:0] LastIdx = PW'(N - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wr_bank_q, wr_bank_d;
    logic [1:0]    full_q, full_d, full_now;
    logic          ovf_q;

    rd_state_e     state_q;
    logic [PW-1:0] rd_ptr_q;
    logic          rd_bank_q;
    logic [QW-1:0] dout_q;
    logic [15:0]   blk_cnt_q;

    logic          wr_acc, wr_last, rd_last, fetch_bank;
    logic [PW-1:0] fetch_addr;
    logic [QW-1:0] wdata, rdata0, rdata1, fetch_data;

    assign wr_acc  = in_valid_i & ~full_q[wr_bank_q];
    assign wr_last = wr_acc & (wr_ptr_q == LastIdx);
    assign rd_last = (state_q == StEmit) & out_ready_i & (rd_ptr_q == LastIdx);
    assign wdata   = requant(din_i, rnd_en_i);

    // full_now includes a bank completing this cycle so the reader can start
    // (or continue back-to-back) without a bubble.
    always_comb begin
        full_now = full_q;
        if (wr_last) begin
            full_now[wr_bank_q] = 1'b1;
        end
        full_d = full_now;
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        if (wr_last) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
        end else if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            ovf_q     <= ovf_q | (in_valid_i & full_q[wr_bank_q]);
        end
    end

    coef_bank u_bank0 (
        .clk_i   (clk_i),
        .we_i    (wr_acc & ~wr_bank_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (fetch_addr),
        .rdata_o (rdata0)
    );

    coef_bank u_bank1 (
        .clk_i   (clk_i),
        .we_i    (wr_acc & wr_bank_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (fetch_addr),
        .rdata_o (rdata1)
    );

    // Address of the word that dout_q loads at this edge.
    assign fetch_bank = rd_last ? ~rd_bank_q : rd_bank_q;
    assign fetch_addr = ((state_q == StEmit) && !rd_last) ? rd_ptr_q + PW'(1) : '0;
    assign fetch_data = fetch_bank ? rdata1 : rdata0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            rd_bank_q <= 1'b0;
            dout_q    <= '0;
            blk_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (full_now[rd_bank_q]) begin
                        state_q  <= StEmit;
                        rd_ptr_q <= '0;
                        dout_q   <= fetch_data;
                    end
                end
                StEmit: begin
                    if (rd_last) begin
                        rd_bank_q <= ~rd_bank_q;
                        rd_ptr_q  <= '0;
                        blk_cnt_q <= blk_cnt_q + 16'd1;
                        if (full_now[~rd_bank_q]) begin
                            dout_q <= fetch_data;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (out_ready_i) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        dout_q   <= fetch_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_out_o = (state_q == StEmit);
    assign dout_o      = {{(DW - QW){dout_q[QW-1]}}, dout_q};
    assign blk_cnt_o   = blk_cnt_q;
    assign ovf_o       = ovf_q;

endmodule

// File: doc/coef_requant.md
# coef_requant

Coefficient requantizer and block buffer between the forward `dct` and the `idct`. It accepts the 64-coefficient block stream from `dct`, one coefficient per cycle while `in_valid` (the `dct` done flag) is high. Each coefficient is reduced to QW significant bits with optional round-to-nearest and saturation. Whole blocks are buffered in a ping-pong pair of 64-entry banks, and each block is replayed sign-extended to DW bits with a level `start_out` that drives the `idct` start.

## Interface
- DW, 32, coefficient word width (in and out)
- SHIFT, 20, arithmetic right-shift applied to each coefficient
- QW, 12, signed width kept after the shift; the result is saturated to this width
- N, 64, coefficients per block
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state is cleared while it is low
- in_valid  in  1  input coefficient valid (driven by the `dct` done flag)
- din  in  DW  signed DCT coefficient
- rnd_en  in  1  1 = round half up before the shift, 0 = truncate; sampled per accepted coefficient
- out_ready  in  1  downstream may take the current `dout`
- start_out  out  1  high while a buffered block is being presented; drives `idct` start
- dout  out  DW  requantized coefficient, sign-extended from QW bits
- blk_cnt  out  16  number of blocks fully emitted; wraps at 65535 -> 0
- ovf  out  1  sticky: a coefficient was dropped because both banks were full

## Operation
- Per accepted coefficient:
  - t = din + (rnd_en ? 2^(SHIFT-1) : 0), computed in DW+1 signed bits.
  - q = t >>> SHIFT.
  - Saturate q to [-2^(QW-1), 2^(QW-1)-1].
  - The QW-bit result is stored.
- Writer:
  - Fills the bank `wr_bank` at `wr_ptr` (0..N-1) on each cycle where `in_valid` is high and that bank is not full.
  - When `in_valid` drops mid-block, `wr_ptr` holds; the same block resumes on the next `in_valid`.
  - At `wr_ptr` = N-1: mark the bank full, toggle `wr_bank`, clear `wr_ptr`.
  - If `in_valid` is high and the target bank is still full, the sample is dropped, `ovf` is set and `wr_ptr` does not advance.
- Reader FSM, states IDLE, EMIT:
  - IDLE -> EMIT when bank `rd_bank` is full. `rd_ptr` = 0 and `start_out` = 1.
  - In EMIT, `dout` = sign-extended bank[rd_bank][rd_ptr].
  - When `out_ready` is high, `rd_ptr` advances.
  - When `out_ready` is high at `rd_ptr` = N-1:
    - bank `rd_bank` is marked empty and `rd_bank` toggles;
    - `blk_cnt` increments;
    - the next state is EMIT again if the other bank is already full (back-to-back, `start_out` stays high), otherwise IDLE.
  - If `out_ready` is low, `dout` and `rd_ptr` hold.
- Simultaneous events:
  - Writer marking bank X full and reader freeing bank Y in the same cycle: both take effect.
  - Reader freeing bank X in the same cycle the writer targets X: X counts as full that cycle, so the sample is dropped and `ovf` is set.
- Reset mid-operation: both banks become empty, pointers return to 0, `wr_bank` = `rd_bank` = 0, FSM returns to IDLE. Bank contents need not be cleared.

## Timing
- Reset values: `start_out` = 0, `dout` = 0, `blk_cnt` = 0, `ovf` = 0.
- Capture is registered. The coefficient accepted in cycle c is in the bank at c+1.
- First-block latency: the N-th accept occurs at cycle c; `start_out` rises at c+1 with coefficient 0 on `dout`.
- Throughput: with `out_ready` held high, one coefficient per cycle. Continuous `in_valid` never overflows.
- `start_out` falls the cycle after the last coefficient of a block is taken, unless the next bank is ready.
- `dout` is registered; it holds its last value while in IDLE.

## Structure
- Package `coef_requant_pkg` holds:
  - constants DW, SHIFT, QW, N;
  - the reader state enum (IDLE, EMIT);
  - the `requant` function (round, shift, saturate).
- Sub-module `coef_bank`: N x QW register file with one write port and one read port, instantiated twice (ping-pong).
- Top level holds the writer pointers, the reader FSM, the full flags and the counters.

## Test plan
- Exactness, `rnd_en` = 0:
  - din = 0x00100000 -> dout = 0x00000001.
  - din = 0xFFF00000 -> dout = 0xFFFFFFFF.
  - din = 0x0017FFFF -> dout = 1.
- Rounding, `rnd_en` = 1:
  - din = 0x0017FFFF -> 1.
  - din = 0x00180000 -> 2.
  - din = 0x7FFFFFFF -> saturated 0x000007FF.
  - din = 0x80000000 -> 0xFFFFF800.
- Single block: 64 consecutive accepts of values 0..63 << 20 with `out_ready` = 1 -> `start_out` high for exactly 64 cycles starting 1 cycle after the last accept, `dout` = 0..63, `blk_cnt` = 1.
- Streaming and backpressure:
  - 3 blocks back-to-back with `out_ready` = 1 -> `start_out` stays high across block boundaries, `ovf` = 0, `blk_cnt` = 3.
  - Same stimulus with `out_ready` = 0 -> third block dropped, `ovf` = 1.
- Gapped input: `in_valid` low for 5 cycles after coefficient 30 -> block completes unchanged after resumption, no extra or missing words.
- Reset mid-EMIT: reset low at `rd_ptr` = 20 -> `start_out` = 0 and `dout` = 0 immediately (asynchronous), `blk_cnt` = 0; next full block emits from coefficient 0.
